// File: rtl/cam_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cam_init_sequencer
// Description : Bring-up controller for the OV7670 camera path. It sequences
//               the camera PWDN/RESET pins, releases the SCCB config engine
//               once the sensor has settled, supervises the config with a
//               timeout and enables the capture datapath on success.
// Options     : CAM_INIT_RETRY_EN - when defined, a config timeout re-runs
//               the camera reset and config up to MAX_RETRIES extra times;
//               when undefined, a timeout goes straight to the fail state.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_init_sequencer #(
   parameter int unsigned PWDN_CYCLES    = 25000,
   parameter int unsigned RST_CYCLES     = 25000,
   parameter int unsigned SETTLE_CYCLES  = 25000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned MAX_RETRIES    = 2
) (
   input  logic       xclk,
   input  logic       reset,
   input  logic       init_req,
   input  logic       cfg_done,
   output logic       cfg_start,
   output logic       cfg_reset,
   output logic       cam_pwdn,
   output logic       cam_resetn,
   output logic       capture_en,
   output logic       busy,
   output logic       init_ok,
   output logic       init_fail,
   output logic [1:0] retry_cnt
);

   // The single dwell timer must hold the largest terminal count.
   localparam int unsigned MAX_AB  = (PWDN_CYCLES > RST_CYCLES) ? PWDN_CYCLES : RST_CYCLES;
   localparam int unsigned MAX_CD  = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TIMER_W-1:0] PWDN_LAST    = TIMER_W'(PWDN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]         RETRY_LIMIT  = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PWDN   = 3'd1,
      S_RST    = 3'd2,
      S_SETTLE = 3'd3,
      S_CFG    = 3'd4,
      S_DONE   = 3'd5,
      S_FAIL   = 3'd6
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_nxt;
   logic [1:0]         retry_nxt;
   logic               run_start;
   logic               retry_take;

   logic cfg_start_nxt;
   logic cfg_reset_nxt;
   logic cam_pwdn_nxt;
   logic cam_resetn_nxt;
   logic capture_en_nxt;
   logic busy_nxt;
   logic init_ok_nxt;
   logic init_fail_nxt;

   // Next-state, timer and retry bookkeeping; outputs are decoded from the
   // next state so every output register changes on the same edge as state.
   always_comb begin
      state_nxt      = state;
      run_start      = 1'b0;
      retry_take     = 1'b0;
      timer_nxt      = '0;
      retry_nxt      = retry_cnt;
      cfg_start_nxt  = 1'b0;
      cfg_reset_nxt  = 1'b1;
      cam_pwdn_nxt   = 1'b1;
      cam_resetn_nxt = 1'b0;
      capture_en_nxt = 1'b0;
      busy_nxt       = 1'b0;
      init_ok_nxt    = 1'b0;
      init_fail_nxt  = 1'b0;

      case (state)
         // init_req is only honoured when no sequence is in progress.
         S_IDLE, S_DONE, S_FAIL: begin
            if (init_req) begin
               state_nxt = S_PWDN;
               run_start = 1'b1;
            end
         end
         S_PWDN: begin
            if (timer == PWDN_LAST) state_nxt = S_RST;
         end
         S_RST: begin
            if (timer == RST_LAST) state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (timer == SETTLE_LAST) state_nxt = S_CFG;
         end
         // Done takes priority over a timeout landing on the same edge.
         S_CFG: begin
            if (cfg_done) begin
               state_nxt = S_DONE;
            end else if (timer == TIMEOUT_LAST) begin
`ifdef CAM_INIT_RETRY_EN
               if (retry_cnt < RETRY_LIMIT) begin
                  state_nxt  = S_RST;
                  retry_take = 1'b1;
               end else begin
                  state_nxt = S_FAIL;
               end
`else
               state_nxt = S_FAIL;
`endif
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Timer restarts on every state entry and only runs in timed states.
      if (state_nxt == state) begin
         case (state)
            S_PWDN, S_RST, S_SETTLE, S_CFG: timer_nxt = timer + 1'b1;
            default:                        timer_nxt = '0;
         endcase
      end

      if (run_start) begin
         retry_nxt = 2'd0;
      end else if (retry_take && (retry_cnt != RETRY_LIMIT)) begin
         retry_nxt = retry_cnt + 2'd1;
      end

      case (state_nxt)
         S_PWDN: begin
            busy_nxt = 1'b1;
         end
         S_RST: begin
            busy_nxt     = 1'b1;
            cam_pwdn_nxt = 1'b0;
         end
         S_SETTLE: begin
            busy_nxt       = 1'b1;
            cam_pwdn_nxt   = 1'b0;
            cam_resetn_nxt = 1'b1;
         end
         S_CFG: begin
            busy_nxt       = 1'b1;
            cam_pwdn_nxt   = 1'b0;
            cam_resetn_nxt = 1'b1;
            cfg_reset_nxt  = 1'b0;
            cfg_start_nxt  = 1'b1;
         end
         // Start drops on entry so the idle engine does not re-run.
         S_DONE: begin
            cam_pwdn_nxt   = 1'b0;
            cam_resetn_nxt = 1'b1;
            cfg_reset_nxt  = 1'b0;
            capture_en_nxt = 1'b1;
            init_ok_nxt    = 1'b1;
         end
         S_FAIL: begin
            init_fail_nxt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // State, dwell timer and registered outputs.
   always_ff @(posedge xclk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         timer      <= '0;
         retry_cnt  <= 2'd0;
         cfg_start  <= 1'b0;
         cfg_reset  <= 1'b1;
         cam_pwdn   <= 1'b1;
         cam_resetn <= 1'b0;
         capture_en <= 1'b0;
         busy       <= 1'b0;
         init_ok    <= 1'b0;
         init_fail  <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         retry_cnt  <= retry_nxt;
         cfg_start  <= cfg_start_nxt;
         cfg_reset  <= cfg_reset_nxt;
         cam_pwdn   <= cam_pwdn_nxt;
         cam_resetn <= cam_resetn_nxt;
         capture_en <= capture_en_nxt;
         busy       <= busy_nxt;
         init_ok    <= init_ok_nxt;
         init_fail  <= init_fail_nxt;
      end
   end

endmodule
`default_nettype wire
